// File: rtl/melee_attack_ctrl_if.sv
// Signal bundle between the melee attack sequencer and its input/drawer side.
// master drives the player inputs and frame timing; slave is the sequencer.
interface melee_attack_ctrl_if;
  logic        mouse_left;
  logic [1:0]  game_active;
  logic        flip_hor_in;
  logic        vsync_in;
  logic        attack_active;
  logic [11:0] anim_x_offset;
  logic        flip_hor_melee;
  logic        hit_window;

  modport master (
    output mouse_left,
    output game_active,
    output flip_hor_in,
    output vsync_in,
    input  attack_active,
    input  anim_x_offset,
    input  flip_hor_melee,
    input  hit_window
  );

  modport slave (
    input  mouse_left,
    input  game_active,
    input  flip_hor_in,
    input  vsync_in,
    output attack_active,
    output anim_x_offset,
    output flip_hor_melee,
    output hit_window
  );
endinterface

// File: rtl/melee_attack_ctrl.sv
// Frame-paced melee swing sequencer: press -> extend -> hold -> retract -> cooldown.
// Optional MELEE_HOLD_REPEAT_EN: a held button restarts the swing when cooldown ends.
module melee_attack_ctrl #(
  parameter int STEP_PX         = 4,
  parameter int MAX_OFFSET      = 24,
  parameter int COOLDOWN_FRAMES = 10
) (
  input logic                clk,
  input logic                rst,
  melee_attack_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EXTEND   = 3'd1,
    ST_HOLD     = 3'd2,
    ST_RETRACT  = 3'd3,
    ST_COOLDOWN = 3'd4
  } state_t;

  localparam int CNT_W = (COOLDOWN_FRAMES > 32'sd1) ? $clog2(COOLDOWN_FRAMES + 32'sd1) : 32'sd1;
  localparam logic [11:0]      STEP_W   = 12'(STEP_PX);
  localparam logic [11:0]      MAX_W    = 12'(MAX_OFFSET);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               NO_COOLDOWN = (COOLDOWN_FRAMES == 32'sd0);

  logic             vsync_d_r;
  logic             tick_r;
  logic             mouse_d_r;
  state_t           state_r;
  state_t           state_next_s;
  logic             pending_r;
  logic             pending_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [11:0]      offset_r;
  logic [11:0]      offset_next_s;
  logic             active_r;
  logic             active_next_s;
  logic             flip_r;
  logic             flip_next_s;
  logic             hit_r;
  logic             hit_next_s;

  logic press_edge_s;
  logic abort_s;
  logic at_peak_s;
  logic at_floor_s;
  logic cnt_last_s;
  logic repeat_s;
  logic start_s;

  assign press_edge_s = bus.mouse_left & ~mouse_d_r;
  assign abort_s      = (bus.game_active == 2'b00);
  // 13-bit sum so a large step near the top of the range cannot wrap
  assign at_peak_s    = ({1'b0, offset_r} + {1'b0, STEP_W}) >= {1'b0, MAX_W};
  assign at_floor_s   = (offset_r <= STEP_W);
  assign cnt_last_s   = (cnt_r <= CNT_ONE);
  assign start_s      = (state_next_s == ST_EXTEND) && (state_r != ST_EXTEND);

`ifdef MELEE_HOLD_REPEAT_EN
  assign repeat_s = bus.mouse_left;
`else
  assign repeat_s = 1'b0;
`endif

  // Frame tick and press-edge history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d_r <= 1'b0;
      tick_r    <= 1'b0;
      mouse_d_r <= 1'b0;
    end else begin
      vsync_d_r <= bus.vsync_in;
      tick_r    <= bus.vsync_in & ~vsync_d_r;
      mouse_d_r <= bus.mouse_left;
    end
  end

  // State and registered datapath/outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      pending_r <= 1'b0;
      cnt_r     <= '0;
      offset_r  <= 12'd0;
      active_r  <= 1'b0;
      flip_r    <= 1'b0;
      hit_r     <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      pending_r <= pending_next_s;
      cnt_r     <= cnt_next_s;
      offset_r  <= offset_next_s;
      active_r  <= active_next_s;
      flip_r    <= flip_next_s;
      hit_r     <= hit_next_s;
    end
  end

  // Next-state decode; only frame ticks advance, abort wins over everything.
  always_comb begin
    state_next_s = state_r;
    if (abort_s) begin
      state_next_s = ST_IDLE;
    end else if (tick_r) begin
      case (state_r)
        ST_IDLE: begin
          if (pending_r || press_edge_s) state_next_s = ST_EXTEND;
          else                           state_next_s = ST_IDLE;
        end
        ST_EXTEND: begin
          if (at_peak_s) state_next_s = ST_HOLD;
          else           state_next_s = ST_EXTEND;
        end
        ST_HOLD: begin
          state_next_s = ST_RETRACT;
        end
        ST_RETRACT: begin
          if (!at_floor_s)     state_next_s = ST_RETRACT;
          else if (!NO_COOLDOWN) state_next_s = ST_COOLDOWN;
          else if (repeat_s)   state_next_s = ST_EXTEND;
          else                 state_next_s = ST_IDLE;
        end
        ST_COOLDOWN: begin
          if (!cnt_last_s)   state_next_s = ST_COOLDOWN;
          else if (repeat_s) state_next_s = ST_EXTEND;
          else               state_next_s = ST_IDLE;
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Datapath updates; swing-start actions apply on any entry into EXTEND.
  always_comb begin
    pending_next_s = pending_r;
    cnt_next_s     = cnt_r;
    offset_next_s  = offset_r;
    active_next_s  = active_r;
    flip_next_s    = flip_r;
    hit_next_s     = hit_r;
    if (abort_s) begin
      pending_next_s = 1'b0;
      cnt_next_s     = '0;
      offset_next_s  = 12'd0;
      active_next_s  = 1'b0;
      flip_next_s    = 1'b0;
      hit_next_s     = 1'b0;
    end else if (start_s) begin
      pending_next_s = 1'b0;
      cnt_next_s     = '0;
      offset_next_s  = 12'd0;
      active_next_s  = 1'b1;
      flip_next_s    = bus.flip_hor_in;
      hit_next_s     = 1'b0;
    end else begin
      if ((state_r == ST_IDLE) && press_edge_s) pending_next_s = 1'b1;
      else                                      pending_next_s = pending_r;
      if (tick_r) begin
        case (state_r)
          ST_EXTEND: begin
            if (at_peak_s) begin
              offset_next_s = MAX_W;
              hit_next_s    = 1'b1;
            end else begin
              offset_next_s = offset_r + STEP_W;
            end
          end
          ST_HOLD: begin
            hit_next_s = 1'b0;
          end
          ST_RETRACT: begin
            if (at_floor_s) begin
              offset_next_s = 12'd0;
              active_next_s = 1'b0;
              cnt_next_s    = CNT_LOAD;
            end else begin
              offset_next_s = offset_r - STEP_W;
            end
          end
          ST_COOLDOWN: begin
            cnt_next_s = cnt_r - CNT_ONE;
          end
          default: begin
            cnt_next_s = cnt_r;
          end
        endcase
      end else begin
        offset_next_s = offset_r;
      end
    end
  end

  assign bus.attack_active  = active_r;
  assign bus.anim_x_offset  = offset_r;
  assign bus.flip_hor_melee = flip_r;
  assign bus.hit_window     = hit_r;

endmodule

// File: tb/tb_melee_attack_ctrl.sv
// Directed testbench for melee_attack_ctrl with hand-computed frame-by-frame expectations.
module tb_melee_attack_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   exp_off [14] = '{0, 4, 8, 12, 16, 20, 24, 24, 20, 16, 12, 8, 4, 0};

  always #5 clk = ~clk;

  melee_attack_ctrl_if bus ();

  melee_attack_ctrl #(
    .STEP_PX(4),
    .MAX_OFFSET(24),
    .COOLDOWN_FRAMES(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // one vsync pulse; returns once the resulting output update is visible
  task automatic tick();
    @(negedge clk) bus.vsync_in = 1'b1;
    @(negedge clk) bus.vsync_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic press();
    @(negedge clk) bus.mouse_left = 1'b1;
    @(negedge clk) bus.mouse_left = 1'b0;
  endtask

  task automatic force_idle();
    @(negedge clk) bus.game_active = 2'b00;
    @(negedge clk) bus.game_active = 2'b01;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mouse_left = 1'b0; bus.game_active = 2'b01; bus.flip_hor_in = 1'b0; bus.vsync_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.attack_active !== 1'b0) begin failures++; $display("FAIL reset_active got %0b want 0", bus.attack_active); end
    checks++; if (bus.anim_x_offset !== 12'd0) begin failures++; $display("FAIL reset_offset got %0d want 0", bus.anim_x_offset); end
    checks++; if (bus.flip_hor_melee !== 1'b0) begin failures++; $display("FAIL reset_flip got %0b want 0", bus.flip_hor_melee); end
    checks++; if (bus.hit_window !== 1'b0) begin failures++; $display("FAIL reset_hit got %0b want 0", bus.hit_window); end
    rst = 1'b0;
    tick();
    checks++; if (bus.attack_active !== 1'b0) begin failures++; $display("FAIL idle_no_press got %0b want 0", bus.attack_active); end
  endtask

  task automatic test_single_swing();
    int act_frames = 0;
    int hit_frames = 0;
    bus.flip_hor_in = 1'b1;
    press();
    for (int t = 0; t < 14; t++) begin
      if (t == 4) press();
      tick();
      if (t == 3) bus.flip_hor_in = 1'b0;
      if (bus.attack_active === 1'b1) act_frames++;
      if (bus.hit_window === 1'b1) hit_frames++;
      checks++;
      if (bus.anim_x_offset !== 12'(exp_off[t])) begin
        failures++; $display("FAIL swing_offset T%0d got %0d want %0d", t, bus.anim_x_offset, exp_off[t]);
      end
      checks++;
      if (bus.attack_active !== ((t < 13) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL swing_active T%0d got %0b want %0b", t, bus.attack_active, (t < 13));
      end
      checks++;
      if (bus.hit_window !== ((t == 6) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL swing_hit T%0d got %0b want %0b", t, bus.hit_window, (t == 6));
      end
      if (t < 13) begin
        checks++;
        if (bus.flip_hor_melee !== 1'b1) begin failures++; $display("FAIL facing_latch T%0d got %0b want 1", t, bus.flip_hor_melee); end
      end
    end
    checks++; if (act_frames != 13) begin failures++; $display("FAIL swing_length got %0d want 13", act_frames); end
    checks++; if (hit_frames != 1) begin failures++; $display("FAIL hit_length got %0d want 1", hit_frames); end
  endtask

  task automatic test_cooldown_press();
    for (int t = 14; t < 24; t++) begin
      if (t == 18 || t == 23) press();
      tick();
      checks++;
      if (bus.attack_active !== 1'b0 || bus.anim_x_offset !== 12'd0) begin
        failures++; $display("FAIL cooldown_idle T%0d got act=%0b off=%0d want act=0 off=0", t, bus.attack_active, bus.anim_x_offset);
      end
    end
    press();
    tick();
    checks++; if (bus.attack_active !== 1'b1) begin failures++; $display("FAIL restart_T24 got %0b want 1", bus.attack_active); end
    checks++; if (bus.anim_x_offset !== 12'd0) begin failures++; $display("FAIL restart_offset got %0d want 0", bus.anim_x_offset); end
    checks++; if (bus.flip_hor_melee !== 1'b0) begin failures++; $display("FAIL restart_flip got %0b want 0", bus.flip_hor_melee); end
  endtask

  task automatic test_abort();
    force_idle();
    bus.flip_hor_in = 1'b1;
    press();
    for (int t = 0; t < 6; t++) tick();
    checks++; if (bus.anim_x_offset !== 12'd20) begin failures++; $display("FAIL abort_pre_offset got %0d want 20", bus.anim_x_offset); end
    @(negedge clk) bus.game_active = 2'b00;
    @(negedge clk);
    checks++;
    if ({bus.attack_active, bus.flip_hor_melee, bus.hit_window} !== 3'b000 || bus.anim_x_offset !== 12'd0) begin
      failures++; $display("FAIL abort_outputs got act=%0b flip=%0b hit=%0b off=%0d want all 0",
                           bus.attack_active, bus.flip_hor_melee, bus.hit_window, bus.anim_x_offset);
    end
    bus.game_active = 2'b10;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++; if (bus.attack_active !== 1'b0) begin failures++; $display("FAIL abort_no_resume F%0d got %0b want 0", t, bus.attack_active); end
    end
    press();
    @(negedge clk) bus.game_active = 2'b00;
    @(negedge clk) bus.game_active = 2'b11;
    tick();
    checks++; if (bus.attack_active !== 1'b0) begin failures++; $display("FAIL abort_clears_pending got %0b want 0", bus.attack_active); end
    bus.game_active = 2'b00;
    press();
    tick();
    checks++; if (bus.attack_active !== 1'b0) begin failures++; $display("FAIL abort_over_tick got %0b want 0", bus.attack_active); end
    bus.game_active = 2'b01;
    tick();
    checks++; if (bus.attack_active !== 1'b0) begin failures++; $display("FAIL abort_over_press got %0b want 0", bus.attack_active); end
  endtask

  task automatic test_simultaneous();
    force_idle();
    @(negedge clk) bus.vsync_in = 1'b1;
    @(negedge clk) begin bus.vsync_in = 1'b0; bus.mouse_left = 1'b1; end
    checks++; if (bus.attack_active !== 1'b0) begin failures++; $display("FAIL simul_early got %0b want 0", bus.attack_active); end
    @(negedge clk);
    checks++; if (bus.attack_active !== 1'b1) begin failures++; $display("FAIL simul_start got %0b want 1", bus.attack_active); end
    bus.mouse_left = 1'b0;
  endtask

  task automatic test_reset_mid_swing();
    force_idle();
    bus.flip_hor_in = 1'b1;
    press();
    for (int t = 0; t < 7; t++) tick();
    checks++;
    if (bus.anim_x_offset !== 12'd24 || bus.hit_window !== 1'b1 || bus.flip_hor_melee !== 1'b1) begin
      failures++; $display("FAIL peak_state got off=%0d hit=%0b flip=%0b want 24/1/1", bus.anim_x_offset, bus.hit_window, bus.flip_hor_melee);
    end
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.attack_active, bus.flip_hor_melee, bus.hit_window} !== 3'b000 || bus.anim_x_offset !== 12'd0) begin
      failures++; $display("FAIL midswing_reset got act=%0b flip=%0b hit=%0b off=%0d want all 0",
                           bus.attack_active, bus.flip_hor_melee, bus.hit_window, bus.anim_x_offset);
    end
    rst = 1'b0;
    bus.flip_hor_in = 1'b0;
    tick();
    checks++; if (bus.attack_active !== 1'b0) begin failures++; $display("FAIL after_reset_idle got %0b want 0", bus.attack_active); end
  endtask

  task automatic test_hold_repeat();
    int act_frames = 0;
    int starts     = 0;
    logic prev     = 1'b0;
    int exp_frames;
    int exp_starts;
`ifdef MELEE_HOLD_REPEAT_EN
    exp_frames = 20; exp_starts = 2;
`else
    exp_frames = 13; exp_starts = 1;
`endif
    force_idle();
    @(negedge clk) bus.mouse_left = 1'b1;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (bus.attack_active === 1'b1) act_frames++;
      if (bus.attack_active === 1'b1 && prev === 1'b0) starts++;
      prev = bus.attack_active;
    end
    bus.mouse_left = 1'b0;
    checks++; if (act_frames != exp_frames) begin failures++; $display("FAIL hold_frames got %0d want %0d", act_frames, exp_frames); end
    checks++; if (starts != exp_starts) begin failures++; $display("FAIL hold_starts got %0d want %0d", starts, exp_starts); end
  endtask

  initial begin
    test_reset();
    test_single_swing();
    test_cooldown_press();
    test_abort();
    test_simultaneous();
    test_reset_mid_swing();
    test_hold_repeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
